varint_decoder: RTL and testbench

Sits downstream of the AXI4 write-slave FSM. Drains the varint input FIFO and its index FIFO, which pop together as 32-bit words with a 10-bit index. Splits each word into bytes and decodes the byte stream as protobuf/LEB128 varints of up to 64 bits. Presents each value with its index on a valid/ready stream to the message parser.

---
 rtl/varint_pkg.sv | 9 +
 rtl/varint_decoder_sat_counter.sv | 14 +
 rtl/varint_decoder.sv | 131 +++++++++++++
 tb/tb_varint_decoder.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/varint_pkg.sv
// varint_pkg: shared constants and one-hot state encoding for the varint decoder
package varint_pkg;
    localparam int MAX_BYTES = 10;
    localparam int IDX_W     = 10;
    localparam int VAL_W     = 64;
    localparam logic [2:0] S_IDLE   = 3'b001;
    localparam logic [2:0] S_DECODE = 3'b010;
    localparam logic [2:0] S_EMIT   = 3'b100;
endpackage

// File: rtl/varint_decoder_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);
    logic [W-1:0] count_q, count_d;
    always_comb count_d = clr ? '0 : (inc && count_q != '1) ? count_q + 1'b1 : count_q;
    always_ff @(posedge clk) count_q <= count_d;
    assign count = count_q;
endmodule

// File: rtl/varint_decoder.sv
// varint_decoder: unpacks 32-bit FIFO words into bytes and decodes LEB128 varints onto a valid/ready stream
module varint_decoder #(
    parameter int MAX_BYTES = varint_pkg::MAX_BYTES,
    parameter int CNT_W     = 16
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           varint_in_fifo_empty,
    input  logic [31:0]                    varint_in_fifo_data,
    input  logic [varint_pkg::IDX_W-1:0]   varint_in_index_data,
    output logic                           varint_in_fifo_pop,
    output logic                           varint_out_valid,
    input  logic                           varint_out_ready,
    output logic [varint_pkg::VAL_W-1:0]   varint_out_value,
    output logic [varint_pkg::IDX_W-1:0]   varint_out_index,
    output logic                           varint_out_err,
    output logic [CNT_W-1:0]               decoded_count,
    output logic [7:0]                     err_count
);
    import varint_pkg::*;
    localparam int CW = $clog2(MAX_BYTES + 1);
    localparam logic [CW-1:0] LAST = CW'(MAX_BYTES - 1);
    localparam logic [CW-1:0] FULL = CW'(MAX_BYTES);

    logic [2:0]       state_q, state_d;
    logic [31:0]      wbuf_q, wbuf_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [VAL_W-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0] sidx_q, sidx_d, cidx_q, cidx_d;
    logic             err_q, err_d, restart_q, restart_d;
    logic [CNT_W-1:0] dcnt_q, dcnt_d;
    logic [7:0]       b;
    logic [6:0]       sh;
    logic             pop, fire;

    always_comb begin
        state_d   = state_q;
        wbuf_d    = wbuf_q;
        ptr_d     = ptr_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        sidx_d    = sidx_q;
        cidx_d    = cidx_q;
        err_d     = err_q;
        restart_d = restart_q;
        dcnt_d    = dcnt_q;
        b         = wbuf_q[8*ptr_q +: 8];
        sh        = 7'(cnt_q) * 7'd7;
        pop       = reset_n && state_q == S_IDLE && !varint_in_fifo_empty;
        fire      = state_q == S_EMIT && varint_out_ready;
        if (state_q == S_DECODE) begin
            // the tenth group only has room for one bit; later groups are overlong
            if (cnt_q < LAST)
                acc_d = acc_q | ({57'd0, b[6:0]} << sh);
            else if (cnt_q == LAST)
                acc_d = {acc_q[63] | b[0], acc_q[62:0]};
            else
                err_d = 1'b1;
            cnt_d   = cnt_q == FULL ? cnt_q : cnt_q + 1'b1;
            state_d = !b[7] ? S_EMIT : ptr_q != 2'd3 ? S_DECODE : S_IDLE;
            ptr_d   = (b[7] && ptr_q != 2'd3) ? ptr_q + 1'b1 : ptr_q;
        end else if (fire) begin
            acc_d  = '0;
            cnt_d  = '0;
            err_d  = 1'b0;
            dcnt_d = dcnt_q + 1'b1;
            if (restart_q || ptr_q != 2'd3) begin
                restart_d = 1'b0;
                sidx_d    = cidx_q;
                ptr_d     = restart_q ? 2'd0 : ptr_q + 1'b1;
                state_d   = S_DECODE;
            end else begin
                state_d = S_IDLE;
            end
        end else if (pop) begin
            wbuf_d = varint_in_fifo_data;
            cidx_d = varint_in_index_data;
            if (cnt_q == '0 || varint_in_index_data == sidx_q) begin
                ptr_d   = 2'd0;
                state_d = S_DECODE;
                sidx_d  = cnt_q == '0 ? varint_in_index_data : sidx_q;
            end else begin
                // writer moved on mid-varint: flush the partial value first, then decode this word
                err_d     = 1'b1;
                restart_d = 1'b1;
                state_d   = S_EMIT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            wbuf_q    <= '0;
            ptr_q     <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            sidx_q    <= '0;
            cidx_q    <= '0;
            err_q     <= 1'b0;
            restart_q <= 1'b0;
            dcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            wbuf_q    <= wbuf_d;
            ptr_q     <= ptr_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            sidx_q    <= sidx_d;
            cidx_q    <= cidx_d;
            err_q     <= err_d;
            restart_q <= restart_d;
            dcnt_q    <= dcnt_d;
        end
    end

    sat_counter #(.W(8)) u_err_cnt (
        .clk   (clk),
        .clr   (!reset_n),
        .inc   (fire && err_q),
        .count (err_count)
    );

    assign varint_in_fifo_pop = pop;
    assign varint_out_valid   = state_q == S_EMIT;
    assign varint_out_value   = acc_q;
    assign varint_out_index   = sidx_q;
    assign varint_out_err     = err_q;
    assign decoded_count      = dcnt_q;
endmodule

// File: tb/tb_varint_decoder.sv
// tb_varint_decoder: randomized scoreboard bench for varint_decoder against a byte-list reference model
module tb_varint_decoder;
    logic        clk = 1'b0, reset_n = 1'b0, empty = 1'b1, ready = 1'b1;
    logic        pop, valid, err;
    logic [31:0] fdata = '0;
    logic [9:0]  fidx = '0, oidx;
    logic [63:0] value;
    logic [15:0] dcount;
    logic [7:0]  ecount;

    always #5 clk = ~clk;

    varint_decoder dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .varint_in_fifo_empty (empty),
        .varint_in_fifo_data  (fdata),
        .varint_in_index_data (fidx),
        .varint_in_fifo_pop   (pop),
        .varint_out_valid     (valid),
        .varint_out_ready     (ready),
        .varint_out_value     (value),
        .varint_out_index     (oidx),
        .varint_out_err       (err),
        .decoded_count        (dcount),
        .err_count            (ecount)
    );

    typedef struct {
        logic [63:0] v;
        logic [9:0]  i;
        logic        e;
    } exp_t;

    exp_t        exp_q[$];
    logic [41:0] fifo[$];
    logic [7:0]  groups[$];
    logic [9:0]  m_sidx = '0;
    int          m_emits = 0, m_errs = 0, n_cmp = 0, n_bad = 0, ready_mode = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // reference: value is the sum of 7-bit groups at weight 2^(7k), truncated to 64 bits
    function automatic logic [63:0] fold();
        logic [63:0] v = '0;
        foreach (groups[k]) if (k < 10) v = v + (64'(groups[k][6:0]) << (7 * k));
        return v;
    endfunction

    task automatic emit_exp(input logic trunc);
        exp_t x;
        x.v = fold();
        x.i = m_sidx;
        x.e = trunc || groups.size() > 10;
        exp_q.push_back(x);
        m_emits++;
        if (x.e) m_errs++;
        groups.delete();
    endtask

    task automatic push(input logic [31:0] d, input logic [9:0] ix);
        logic [7:0] bt;
        fifo.push_back({ix, d});
        if (groups.size() > 0 && ix != m_sidx) emit_exp(1'b1);
        if (groups.size() == 0) m_sidx = ix;
        for (int k = 0; k < 4; k++) begin
            bt = d[8*k +: 8];
            groups.push_back(bt);
            if (!bt[7]) begin
                emit_exp(1'b0);
                m_sidx = ix;
            end
        end
    endtask

    task automatic drain(input int budget);
        int t = 0;
        while ((fifo.size() != 0 || exp_q.size() != 0 || valid) && t < budget) begin
            @(negedge clk);
            t++;
        end
        if (t >= budget) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: %0d words and %0d values still pending", fifo.size(), exp_q.size());
        end
        repeat (3) @(negedge clk);
    endtask

    always @(posedge clk) if (pop && fifo.size() > 0) void'(fifo.pop_front());

    always @(negedge clk) begin
        empty = fifo.size() == 0;
        {fidx, fdata} = empty ? 42'd0 : fifo[0];
    end

    always @(posedge clk) begin
        #1;
        ready = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? ($urandom_range(0, 3) != 0) : 1'b0;
    end

    always @(negedge clk) begin : mon
        exp_t x;
        static int seen_out = 0, seen_err = 0;
        static logic stalled = 1'b0, he = 1'b0;
        static logic [63:0] hv = '0;
        static logic [9:0] hi = '0;
        if (!reset_n) begin
            seen_out = 0;
            seen_err = 0;
            stalled  = 1'b0;
        end else begin
            if (valid) chk("pop_while_valid", 64'(pop), 64'(0));
            if (stalled) begin
                chk("stall_valid", 64'(valid), 64'(1));
                chk("stall_value", value, hv);
                chk("stall_index", 64'(oidx), 64'(hi));
                chk("stall_err", 64'(err), 64'(he));
            end
            if (valid && ready) begin
                chk("decoded_count", 64'(dcount), 64'(seen_out[15:0]));
                chk("err_count", 64'(ecount), 64'(seen_err > 255 ? 255 : seen_err));
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_output: got value %0h index %0d, expected nothing", value, oidx);
                end else begin
                    x = exp_q.pop_front();
                    chk("value", value, x.v);
                    chk("index", 64'(oidx), 64'(x.i));
                    chk("err", 64'(err), 64'(x.e));
                end
                seen_out++;
                if (err) seen_err++;
                stalled = 1'b0;
            end else begin
                stalled = valid;
                hv = value;
                hi = oidx;
                he = err;
            end
        end
    end

    initial begin
        logic [31:0] w;
        logic [9:0]  cur;
        int          t;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 64'(valid), 64'(0));
        chk("rst_pop", 64'(pop), 64'(0));
        chk("rst_value", value, 64'(0));
        chk("rst_index", 64'(oidx), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        chk("rst_dcount", 64'(dcount), 64'(0));
        chk("rst_ecount", 64'(ecount), 64'(0));
        @(posedge clk); #1 reset_n = 1'b1;

        push(32'h0000_0196, 10'd2);
        drain(200);
        chk("t1_dcount", 64'(dcount), 64'(3));
        push(32'hFFFF_FFFF, 10'd5);
        push(32'h0000_000F, 10'd5);
        drain(200);
        push(32'hFFFF_FFFF, 10'd1);
        push(32'hFFFF_FFFF, 10'd1);
        push(32'hFFFF_FFFF, 10'd1);
        push(32'h0000_0000, 10'd1);
        drain(300);
        chk("t3_ecount", 64'(ecount), 64'(1));
        push(32'h8080_8080, 10'd3);
        push(32'h0000_0005, 10'd4);
        drain(200);

        ready_mode = 2;
        push(32'h0000_0007, 10'd9);
        repeat (12) @(negedge clk);
        chk("bp_valid", 64'(valid), 64'(1));
        chk("bp_value", value, 64'(7));
        chk("bp_index", 64'(oidx), 64'(9));
        ready_mode = 0;
        drain(200);

        push(32'h8080_8096, 10'd7);
        t = 0;
        while (fifo.size() != 0 && t < 100) begin @(negedge clk); t++; end
        chk("rst_mid_popped", 64'(fifo.size()), 64'(0));
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b0;
        groups.delete();
        m_emits = 0;
        m_errs  = 0;
        @(posedge clk); #1 reset_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_dcount", 64'(dcount), 64'(0));
        chk("rst_mid_valid", 64'(valid), 64'(0));
        push(32'h0000_0001, 10'd8);
        drain(200);
        chk("rst_mid_after", 64'(dcount), 64'(4));

        ready_mode = 1;
        cur = 10'd20;
        for (int n = 0; n < 200; n++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            @(posedge clk); #1;
            for (int k = 0; k < 4; k++)
                w[8*k +: 8] = $urandom_range(0, 2) == 0 ? 8'($urandom_range(0, 127)) : 8'($urandom_range(128, 255));
            if ($urandom_range(0, 7) == 0) w = 32'hFFFF_FFFF;
            if ($urandom_range(0, 9) == 0) cur = 10'($urandom);
            push(w, cur);
        end
        push(32'h0, cur);
        drain(20000);

        ready_mode = 0;
        for (int k = 0; k < 300; k++) push(32'h8080_8080, 10'(k + 100));
        push(32'h0, 10'd399);
        drain(20000);

        chk("final_dcount", 64'(dcount), 64'(m_emits[15:0]));
        chk("final_ecount", 64'(ecount), 64'(m_errs > 255 ? 255 : m_errs));
        chk("final_pending", 64'(exp_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
